// File: rtl/requant_pkg.sv
// Shared constants and helpers for the fixed-point requantizer: rounding modes,
// shift derivation, parameter sanity check and clamp values.
package requant_pkg;

  localparam logic [1:0] RND_TRUNC     = 2'b00;
  localparam logic [1:0] RND_HALF_UP   = 2'b01;
  localparam logic [1:0] RND_HALF_EVEN = 2'b10;

  function automatic int calc_sh(input int in_frac, input int out_frac);
    return in_frac - out_frac;
  endfunction

  // SH >= 2 keeps the guard bit and at least one sticky bit addressable
  function automatic bit cfg_ok(input int in_w, input int in_frac,
                                input int out_w, input int out_frac);
    return (out_frac <= in_frac) &&
           ((out_w - 1 - out_frac) <= (in_w - 1 - in_frac)) &&
           ((in_frac - out_frac) >= 2) && (out_w <= 64) && (out_w >= 2);
  endfunction

  function automatic logic [63:0] clamp_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] clamp_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/requant_sat_counter.sv
// Saturating event counter; clear wins over a same-cycle increment.
module requant_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                     r_count <= '0;
    else if (i_clr)                r_count <= '0;
    else if (i_inc && !(&r_count)) r_count <= r_count + CNT_W'(1);
  end

  assign o_count = r_count;

endmodule

// File: rtl/fixed_requant_pipe.sv
// Two-stage round-then-saturate requantizer with valid/ready on both sides.
// Optional REQUANT_SYM_SAT_EN: symmetric output range (most-negative code excluded).
module fixed_requant_pipe
  import requant_pkg::*;
#(
  parameter int IN_W     = 50,
  parameter int IN_FRAC  = 28,
  parameter int OUT_W    = 25,
  parameter int OUT_FRAC = 14,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             sat_clr,
  output logic [CNT_W-1:0] sat_count
);

  localparam int SH = calc_sh(IN_FRAC, OUT_FRAC);
  localparam int RW = IN_W - SH + 1;
  localparam logic [OUT_W-1:0] MAXV     = OUT_W'(clamp_max(OUT_W));
  localparam logic [OUT_W-1:0] MIN_FULL = OUT_W'(clamp_min(OUT_W));
`ifdef REQUANT_SYM_SAT_EN
  localparam logic [OUT_W-1:0] MINV = MIN_FULL | OUT_W'(1);
`else
  localparam logic [OUT_W-1:0] MINV = MIN_FULL;
`endif

  if (!cfg_ok(IN_W, IN_FRAC, OUT_W, OUT_FRAC)) begin : g_bad_cfg
    $error("fixed_requant_pipe: unsupported width/fraction parameters");
  end

  logic [2:1]       r_vld_pipe;
  logic [RW-1:0]    r_s1;
  logic [OUT_W-1:0] r_out_data;
  logic             r_out_sat;

  logic             w_adv, w_g, w_s, w_inc, w_hi_ok, w_sat;
  logic [RW-1:0]    w_base, w_rnd;
  logic [OUT_W-1:0] w_q;

  assign w_adv    = !r_vld_pipe[2] || out_ready;
  assign in_ready = w_adv;

  // One extra sign bit so a +1 increment on the max input cannot wrap
  assign w_base = {in_data[IN_W-1], in_data[IN_W-1:SH]};
  assign w_g    = in_data[SH-1];
  assign w_s    = |in_data[SH-2:0];

  always_comb begin
    w_inc = 1'b0;
    case (in_mode)
      RND_HALF_UP:   w_inc = w_g;
      RND_HALF_EVEN: w_inc = w_g && (w_s || w_base[0]);
      default:       w_inc = 1'b0;
    endcase
  end

  assign w_rnd = w_base + {{(RW-1){1'b0}}, w_inc};

  // In range when everything from the output sign bit upward agrees
  assign w_hi_ok = (&r_s1[RW-1:OUT_W-1]) || !(|r_s1[RW-1:OUT_W-1]);

  always_comb begin
    w_sat = 1'b0;
    w_q   = r_s1[OUT_W-1:0];
    if (!w_hi_ok) begin
      w_sat = 1'b1;
      w_q   = r_s1[RW-1] ? MINV : MAXV;
    end
`ifdef REQUANT_SYM_SAT_EN
    else if (r_s1[OUT_W-1:0] == MIN_FULL) begin
      w_sat = 1'b1;
      w_q   = MINV;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_pipe <= '0;
      r_s1       <= '0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
    end else if (w_adv) begin
      r_vld_pipe <= {r_vld_pipe[1], in_valid};
      if (in_valid) r_s1 <= w_rnd;
      if (r_vld_pipe[1]) begin
        r_out_data <= w_q;
        r_out_sat  <= w_sat;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign out_valid = r_vld_pipe[2];

  requant_sat_counter #(.CNT_W(CNT_W)) u_sat_cnt (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_inc   (r_vld_pipe[2] && out_ready && r_out_sat),
    .i_clr   (sat_clr),
    .o_count (sat_count)
  );

endmodule
